// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: issues and paces multi-cycle mult/shift ops on the iterative units
// Ports:
//   clk_i, reset_n_i            clock, asynchronous active-low reset
//   instr_valid_i, opcode_i,
//   shamt_i                     decoded instruction, shift amount
//   stall_o                     hold PC/IR (combinational)
//   busy_o                      sequencer not idle (registered)
//   op_load_o                   operand capture strobe on issue
//   mul_step_o, shift_step_o    per-cycle iteration strobes
//   shift_type_o                00 sll, 01 srl, 10 sra, 11 ror
//   seq_write_o                 single register-file write pulse
module multicycle_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int MUL_CYCLES = 8
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       instr_valid_i,
    input  logic [7:0] opcode_i,
    input  logic [7:0] shamt_i,
    output logic       stall_o,
    output logic       busy_o,
    output logic       op_load_o,
    output logic       mul_step_o,
    output logic       shift_step_o,
    output logic [1:0] shift_type_o,
    output logic       seq_write_o
);
    localparam int CW = $clog2((MUL_CYCLES > DATA_WIDTH ? MUL_CYCLES : DATA_WIDTH) + 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] MUL   = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] WB    = 2'd3;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    type_q, type_d;
    logic          is_mul, is_shift, is_ror, issue;
    logic [31:0]   shamt_w;
    logic [CW-1:0] n;
    assign is_mul   = opcode_i == 8'h09;
    assign is_shift = opcode_i >= 8'h0A && opcode_i <= 8'h0D;
    assign is_ror   = opcode_i == 8'h0D;
    // Gated by reset so no combinational strobe leaks out while held in reset.
    assign issue    = reset_n_i && state_q == IDLE && instr_valid_i && (is_mul || is_shift);
    assign shamt_w  = {24'd0, shamt_i};
    // Rotates wrap modulo the width; plain shifts saturate at the width.
    assign n = CW'(is_ror ? shamt_w % 32'(DATA_WIDTH)
                          : (shamt_w > 32'(DATA_WIDTH) ? 32'(DATA_WIDTH) : shamt_w));
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        type_d  = type_q;
        if (issue) begin
            state_d = is_mul ? MUL : (n == '0 ? WB : SHIFT);
            cnt_d   = is_mul ? CW'(MUL_CYCLES) : n;
            type_d  = is_mul ? type_q : 2'(opcode_i - 8'h0A);
        end else if (state_q == MUL || state_q == SHIFT) begin
            cnt_d   = cnt_q - 1'b1;
            state_d = cnt_q == CW'(1) ? WB : state_q;
        end else if (state_q == WB) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            type_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            type_q  <= type_d;
        end
    end
    assign busy_o       = state_q != IDLE;
    assign stall_o      = (busy_o && state_q != WB) || issue;
    assign op_load_o    = issue;
    assign mul_step_o   = state_q == MUL;
    assign shift_step_o = state_q == SHIFT;
    assign seq_write_o  = state_q == WB;
    assign shift_type_o = type_q;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: directed self-checking bench for multicycle_sequencer
module tb_multicycle_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       iv = 1'b0;
    logic [7:0] op = 8'h00;
    logic [7:0] sh = 8'h00;
    logic       stall, busy, op_load, mul_step, shift_step, seq_write;
    logic [1:0] shift_type;
    logic [5:0] outs;
    int errors = 0;
    int checks = 0;

    multicycle_sequencer #(.DATA_WIDTH(8), .MUL_CYCLES(8)) dut (
        .clk_i(clk), .reset_n_i(rst_n), .instr_valid_i(iv), .opcode_i(op), .shamt_i(sh),
        .stall_o(stall), .busy_o(busy), .op_load_o(op_load), .mul_step_o(mul_step),
        .shift_step_o(shift_step), .shift_type_o(shift_type), .seq_write_o(seq_write)
    );

    always #5 clk = ~clk;
    // {stall, busy, op_load, mul_step, shift_step, seq_write}
    assign outs = {stall, busy, op_load, mul_step, shift_step, seq_write};

    localparam logic [5:0] O_IDLE  = 6'b000000;
    localparam logic [5:0] O_ISSUE = 6'b101000;
    localparam logic [5:0] O_MUL   = 6'b110100;
    localparam logic [5:0] O_SHIFT = 6'b110010;
    localparam logic [5:0] O_WB    = 6'b010001;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; iv = 1'b1; op = 8'h09; sh = 8'h00;
        repeat (2) tick();
        #4;
        checks++;
        if (outs !== O_IDLE || shift_type !== 2'b00) begin
            errors++;
            $display("FAIL reset_hold: got outs=%b type=%b expected outs=%b type=00", outs, shift_type, O_IDLE);
        end
        tick();
        iv = 1'b0; rst_n = 1'b1;
        #4;
        checks++;
        if (outs !== O_IDLE || shift_type !== 2'b00) begin
            errors++;
            $display("FAIL reset_release: got outs=%b type=%b expected outs=%b type=00", outs, shift_type, O_IDLE);
        end
    endtask

    task automatic test_mult();
        tick();
        iv = 1'b1; op = 8'h09;
        #4;
        checks++;
        if (outs !== O_ISSUE) begin
            errors++;
            $display("FAIL mult_issue: got %b expected %b", outs, O_ISSUE);
        end
        tick();
        iv = 1'b0; op = 8'h00;
        #4;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (outs !== O_MUL) begin
                errors++;
                $display("FAIL mult_step%0d: got %b expected %b", i, outs, O_MUL);
            end
            tick();
            #4;
        end
        checks++;
        if (outs !== O_WB) begin
            errors++;
            $display("FAIL mult_wb: got %b expected %b", outs, O_WB);
        end
        tick();
        #4;
        checks++;
        if (outs !== O_IDLE) begin
            errors++;
            $display("FAIL mult_idle: got %b expected %b", outs, O_IDLE);
        end
    endtask

    task automatic test_shift_counts();
        logic [7:0] t_op [3] = '{8'h0C, 8'h0A, 8'h0D};
        logic [7:0] t_sh [3] = '{8'd3, 8'd200, 8'd10};
        int         t_n  [3] = '{3, 8, 2};
        logic [1:0] t_ty [3] = '{2'b10, 2'b00, 2'b11};
        for (int v = 0; v < 3; v++) begin
            tick();
            iv = 1'b1; op = t_op[v]; sh = t_sh[v];
            #4;
            checks++;
            if (outs !== O_ISSUE) begin
                errors++;
                $display("FAIL shift%0d_issue: got %b expected %b", v, outs, O_ISSUE);
            end
            tick();
            iv = 1'b0; op = 8'h00; sh = 8'h00;
            #4;
            for (int k = 0; k < t_n[v]; k++) begin
                checks++;
                if (outs !== O_SHIFT || shift_type !== t_ty[v]) begin
                    errors++;
                    $display("FAIL shift%0d_step%0d: got %b/%b expected %b/%b", v, k, outs, shift_type, O_SHIFT, t_ty[v]);
                end
                tick();
                #4;
            end
            checks++;
            if (outs !== O_WB || shift_type !== t_ty[v]) begin
                errors++;
                $display("FAIL shift%0d_wb: got %b/%b expected %b/%b", v, outs, shift_type, O_WB, t_ty[v]);
            end
            tick();
            #4;
            checks++;
            if (outs !== O_IDLE) begin
                errors++;
                $display("FAIL shift%0d_idle: got %b expected %b", v, outs, O_IDLE);
            end
        end
    endtask

    task automatic test_zero_shift();
        tick();
        iv = 1'b1; op = 8'h0B; sh = 8'd0;
        #4;
        checks++;
        if (outs !== O_ISSUE) begin
            errors++;
            $display("FAIL zero_issue: got %b expected %b", outs, O_ISSUE);
        end
        tick();
        iv = 1'b0; op = 8'h00;
        #4;
        checks++;
        if (outs !== O_WB || shift_type !== 2'b01) begin
            errors++;
            $display("FAIL zero_wb: got %b/%b expected %b/01", outs, shift_type, O_WB);
        end
        tick();
        #4;
        checks++;
        if (outs !== O_IDLE) begin
            errors++;
            $display("FAIL zero_idle: got %b expected %b", outs, O_IDLE);
        end
    endtask

    task automatic test_single_cycle();
        logic [7:0] ops [3] = '{8'h02, 8'h07, 8'hFF};
        for (int v = 0; v < 3; v++) begin
            tick();
            iv = 1'b1; op = ops[v]; sh = 8'd5;
            #4;
            checks++;
            if (outs !== O_IDLE) begin
                errors++;
                $display("FAIL single_%h: got %b expected %b", ops[v], outs, O_IDLE);
            end
        end
        tick();
        iv = 1'b0; op = 8'h09;
        #4;
        checks++;
        if (outs !== O_IDLE) begin
            errors++;
            $display("FAIL novalid_now: got %b expected %b", outs, O_IDLE);
        end
        tick();
        op = 8'h00; sh = 8'h00;
        #4;
        checks++;
        if (outs !== O_IDLE) begin
            errors++;
            $display("FAIL novalid_next: got %b expected %b", outs, O_IDLE);
        end
    endtask

    task automatic test_back_to_back();
        int writes = 0;
        logic [5:0] exp_seq [5] = '{O_ISSUE, O_SHIFT, O_SHIFT, O_WB, O_IDLE};
        tick();
        iv = 1'b1; op = 8'h09;
        #4;
        checks++;
        if (outs !== O_ISSUE) begin
            errors++;
            $display("FAIL b2b_mult_issue: got %b expected %b", outs, O_ISSUE);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            iv = 1'b1; op = (i < 3) ? 8'h09 : 8'h02;
            #4;
            checks++;
            if (outs !== O_MUL) begin
                errors++;
                $display("FAIL b2b_mul%0d: got %b expected %b", i, outs, O_MUL);
            end
        end
        tick();
        iv = 1'b1; op = 8'h0A; sh = 8'd2;
        #4;
        writes += int'(seq_write);
        checks++;
        if (outs !== O_WB) begin
            errors++;
            $display("FAIL b2b_mult_wb: got %b expected %b", outs, O_WB);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 1) begin
                iv = 1'b0; op = 8'h00; sh = 8'h00;
            end
            #4;
            writes += int'(seq_write);
            checks++;
            if (outs !== exp_seq[i]) begin
                errors++;
                $display("FAIL b2b_sll%0d: got %b expected %b", i, outs, exp_seq[i]);
            end
        end
        checks++;
        if (writes !== 2) begin
            errors++;
            $display("FAIL b2b_writes: got %0d expected 2", writes);
        end
    endtask

    task automatic test_reset_midop();
        int writes = 0;
        tick();
        iv = 1'b1; op = 8'h09;
        tick();
        iv = 1'b0; op = 8'h00;
        repeat (3) tick();
        #2;
        checks++;
        if (outs !== O_MUL) begin
            errors++;
            $display("FAIL rst_mid_pre: got %b expected %b", outs, O_MUL);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs !== O_IDLE) begin
            errors++;
            $display("FAIL rst_mid_now: got %b expected %b", outs, O_IDLE);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #4;
            writes += int'(seq_write);
            tick();
        end
        checks++;
        if (writes !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_after: got writes=%0d busy=%b expected writes=0 busy=0", writes, busy);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_shift_counts();
        test_zero_shift();
        test_single_cycle();
        test_back_to_back();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Sequences multi-cycle execute operations (mult, sll, srl, sra, ror) on the CPU's iterative multiplier and shifter.
- Sits beside the combinational control unit and decodes the same 8-bit opcode.
- Stalls the PC while a multi-cycle operation runs, drives per-cycle step strobes into the iterative units, and issues a single register-write pulse when the result is ready.
- Single-cycle opcodes pass through untouched.

Parameters:
- DATA_WIDTH, 8, datapath width; sets maximum shift steps.
- MUL_CYCLES, 8, number of multiplier step cycles (>=1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  a decoded instruction is present on opcode/shamt this cycle.
- opcode  in  8  instruction opcode (same encoding as the control unit).
- shamt  in  8  immediate shift amount (unsigned).
- stall  out  1  hold PC/instruction register; combinational.
- busy  out  1  FSM not in IDLE; registered.
- op_load  out  1  one-cycle strobe: iterative unit captures operands; combinational.
- mul_step  out  1  multiplier performs one iteration this cycle.
- shift_step  out  1  shifter performs one 1-bit shift this cycle.
- shift_type  out  2  00 sll, 01 srl, 10 sra, 11 ror; registered with the op.
- seq_write  out  1  one-cycle register-file write enable for the multi-cycle result.

Behaviour:
- Opcode classes:
  - Multi-cycle opcodes: 0x09 mult, 0x0A sll, 0x0B srl, 0x0C sra, 0x0D ror.
  - All others, including unknown opcodes, are single-cycle and ignored: no stall, no strobes.
- States: IDLE, MUL, SHIFT, WB. A down-counter of width clog2(max(MUL_CYCLES, DATA_WIDTH)+1) tracks remaining steps.
- Reset (async, any state): state=IDLE, counter=0, shift_type=00. All outputs 0 while reset_n=0 and in the first cycle after release.
- IDLE, with instr_valid=1 and a multi-cycle opcode (the issue cycle):
  - stall=1 and op_load=1, combinationally in the same cycle.
  - mult: next state MUL, counter=MUL_CYCLES.
  - shift: shift_type latched.
  - Effective shift count N:
    - sll/srl/sra: N = min(shamt, DATA_WIDTH).
    - ror: N = shamt mod DATA_WIDTH.
  - N=0: next state WB directly.
  - N>0: next state SHIFT, counter=N.
- IDLE, otherwise: all outputs 0.
- MUL: stall=1, mul_step=1. Counter decrements each cycle. When the counter equals 1, next state is WB. Exactly MUL_CYCLES steps are issued.
- SHIFT: stall=1, shift_step=1. Counter decrements each cycle. When the counter equals 1, next state is WB. Exactly N steps are issued.
- WB:
  - seq_write=1 and stall=0, so the PC advances and the register file writes on the same edge.
  - Next state is always IDLE.
  - instr_valid/opcode are ignored in WB; the old instruction must not re-trigger.
- During MUL/SHIFT/WB, opcode/shamt changes are ignored. The operation uses the values captured at issue.
- Latency:
  - mult: MUL_CYCLES+2 cycles from issue to WB inclusive.
  - shift: N+2 cycles, or 2 cycles when N=0.
- Back-to-back: a multi-cycle op presented in the cycle after WB (now IDLE) issues normally. There are no bubbles beyond WB.
- Reset asserted mid-operation: immediate return to IDLE. No seq_write is issued and the operation is discarded.
- busy = (state != IDLE). stall = busy&&state!=WB || issue.

Test Plan:
- Reset mid-op and default state: hold reset_n=0, pulse clk -> all outputs 0. Release, issue mult, assert reset_n=0 during the 4th MUL cycle -> outputs 0 immediately, no seq_write afterwards.
- mult, MUL_CYCLES=8, opcode=0x09, instr_valid=1:
  - Issue cycle: op_load=1, stall=1.
  - Next 8 cycles: mul_step=1, stall=1.
  - Cycle 10: seq_write=1, stall=0.
  - Exactly 8 mul_step pulses and 1 seq_write.
- Shift count rules:
  - sra 0x0C with shamt=3 -> shift_type=10, 3 shift_step cycles, then WB.
  - sll with shamt=200 -> 8 steps.
  - ror with shamt=10 -> 2 steps, shift_type=11.
- Zero shift: srl with shamt=0 -> issue cycle (stall=1, op_load=1), next cycle WB with seq_write=1. No shift_step.
- Single-cycle and unknown opcodes: add 0x02, beq 0x07, unknown 0xFF with instr_valid=1 -> stall=0, busy=0, no strobes. Multi-cycle opcode with instr_valid=0 -> no issue.
- Back-to-back and operand capture:
  - mult immediately followed by sll shamt=2 -> second op issues the cycle after WB, 2 steps, two distinct seq_write pulses.
  - Change opcode to 0x02 mid-MUL -> sequence unaffected.
